// File: rtl/song_recorder_if.sv
// Song RAM write port: the recorder drives it, the RAM (or a monitor) listens.
interface song_recorder_if #(
    parameter int ADDR_BITS = 10
);
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [7:0]           wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/song_recorder.sv
// Records a live note once per note period into one of four song slots and
// closes the song with the 7'h7F finish marker that song_select expects.
module song_recorder #(
    parameter int          ADDR_BITS   = 10,
    parameter logic [25:0] NOTE_LENGTH = 26'd50_000_000,
    parameter logic [9:0]  SLOT_SIZE   = 10'd250
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       song_slot,
    input  logic [6:0]       note_in,
    song_recorder_if.master  ram,
    output logic             recording,
    output logic             done,
    output logic [7:0]       note_count,
    output logic [1:0]       state_out
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECORD    = 2'd1,
        TERMINATE = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t               state, state_d;
    logic [25:0]          cnt, cnt_d;
    logic [ADDR_BITS-1:0] base, base_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           data_q, data_d;
    logic [7:0]           count_d;
    logic                 wr_en_q, wr_en_d;
    logic                 sample;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        base_d  = base;
        count_d = note_count;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        sample  = (state == RECORD) && (cnt == NOTE_LENGTH - 26'd1);
        case (state)
            IDLE, DONE: begin
                // Counter preloaded so the very first RECORD cycle samples.
                if (start) begin
                    state_d = RECORD;
                    cnt_d   = NOTE_LENGTH - 26'd1;
                    base_d  = ADDR_BITS'(SLOT_SIZE) * ADDR_BITS'(song_slot);
                    count_d = 8'd0;
                end
            end
            RECORD: begin
                cnt_d = sample ? 26'd0 : cnt + 26'd1;
                if (sample) begin
                    wr_en_d = 1'b1;
                    addr_d  = base + ADDR_BITS'(note_count);
                    data_d  = (note_in == 7'h7F) ? 8'h00 : {1'b0, note_in};
                    count_d = note_count + 8'd1;
                end
                // Last data entry leaves room for the marker inside the slot.
                if (stop || (sample && 10'(note_count) == SLOT_SIZE - 10'd2))
                    state_d = TERMINATE;
            end
            TERMINATE: begin
                wr_en_d = 1'b1;
                addr_d  = base + ADDR_BITS'(note_count);
                data_d  = 8'h7F;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            cnt        <= '0;
            base       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
            note_count <= '0;
            recording  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            base       <= base_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_en_q    <= wr_en_d;
            note_count <= count_d;
            recording  <= (state_d == RECORD) || (state_d == TERMINATE);
            done       <= (state_d == DONE);
        end
    end

    assign state_out   = state;
    assign ram.wr_en   = wr_en_q;
    assign ram.wr_addr = addr_q;
    assign ram.wr_data = data_q;

endmodule

// File: tb/tb_song_recorder.sv
// Scoreboard bench for song_recorder with NOTE_LENGTH=4: every expected RAM
// write (cycle, address, data) is queued by the driver and matched by a monitor.
module tb_song_recorder;
    localparam int NL = 4;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] song_slot = 2'd0;
    logic [6:0] note_in = 7'd0;
    logic       recording, done;
    logic [7:0] note_count;
    logic [1:0] state_out;

    song_recorder_if #(.ADDR_BITS(10)) bus ();

    song_recorder #(.ADDR_BITS(10), .NOTE_LENGTH(26'd4), .SLOT_SIZE(10'd250)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .stop(stop),
        .song_slot(song_slot), .note_in(note_in), .ram(bus),
        .recording(recording), .done(done), .note_count(note_count),
        .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t        q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [6:0] tb_notes[8];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int exp_data(input logic [6:0] n);
        return (n == 7'h7F) ? 0 : int'(n);
    endfunction

    // Monitor: a write must appear exactly in the cycle the scoreboard expects.
    always @(negedge clk_in) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                wr_t e;
                e = q.pop_front();
                chk("wr_en", 32'(bus.wr_en), 32'd1);
                chk("wr_addr", 32'(bus.wr_addr), e.addr);
                chk("wr_data", 32'(bus.wr_data), e.data);
            end else if (bus.wr_en === 1'b1) begin
                chk("spurious_wr", 32'(bus.wr_addr), 32'hFFFF_FFFF);
            end
        end
    end

    // mode 0: stop one cycle after last write; 1: stop on last sample;
    // 2: run until the slot fills; 3: reset one cycle after last write.
    task automatic record(input logic [1:0] slot, input int n, input int mode, input bit poke);
        int k, base, p, w;
        base = 250 * int'(slot);
        k = cyc;
        start = 1'b1; song_slot = slot; stop = poke; note_in = tb_notes[0];
        tick();
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < n; i++) begin
            note_in = tb_notes[i % 8];
            q.push_back('{k + 2 + NL * i, base + i, exp_data(tb_notes[i % 8])});
            if (mode == 1 && i == n - 1) stop = 1'b1;
            if (poke && i == 1) begin start = 1'b1; song_slot = slot + 2'd1; end
            tick();
            stop = 1'b0; start = 1'b0; song_slot = slot;
            chk("note_count_run", 32'(note_count), i + 1);
            if (i == 0) chk("recording_run", 32'(recording), 32'd1);
            if (i < n - 1) repeat (NL - 1) tick();
        end
        w = cyc;
        case (mode)
            0: begin
                tick();
                p = cyc; stop = 1'b1;
                tick();
                stop = 1'b0;
                q.push_back('{p + 2, base + n, 8'h7F});
            end
            1: begin
                chk("state_terminate", 32'(state_out), 32'd2);
                q.push_back('{w + 1, base + n, 8'h7F});
            end
            2: q.push_back('{w + 1, base + 249, 8'h7F});
            default: begin
                rst_in = 1'b1;
                tick();
                rst_in = 1'b0;
                chk("rst_mid_state", 32'(state_out), 32'd0);
                chk("rst_mid_wr_en", 32'(bus.wr_en), 32'd0);
                chk("rst_mid_count", 32'(note_count), 32'd0);
                chk("rst_mid_rec", 32'(recording), 32'd0);
                repeat (2 * NL) tick();
                return;
            end
        endcase
        repeat (3) tick();
        chk("done", 32'(done), 32'd1);
        chk("state_done", 32'(state_out), 32'd3);
        chk("recording_off", 32'(recording), 32'd0);
        chk("note_count_final", 32'(note_count), (mode == 2) ? 249 : n);
        chk("queue_empty", 32'(q.size()), 32'd0);
        repeat (NL) tick();
        chk("done_hold", 32'(done), 32'd1);
    endtask

    initial begin
        start = 1'b1; stop = 1'b1;
        song_slot = 2'($urandom_range(0, 3));
        note_in = 7'($urandom_range(0, 127));
        tick();
        tick();
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_recording", 32'(recording), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_note_count", 32'(note_count), 32'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        start = 1'b0; stop = 1'b0; rst_in = 1'b0;
        mon_en = 1'b1;
        tick();

        tb_notes = '{7'd60, 7'd62, 7'd64, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5};
        record(2'd1, 3, 0, 1'b0);

        tb_notes = '{default: 7'd5};
        record(2'd3, 249, 2, 1'b0);

        tb_notes = '{7'h7F, 7'd9, 7'd9, 7'd9, 7'd9, 7'd9, 7'd9, 7'd9};
        record(2'd0, 1, 0, 1'b0);

        tb_notes = '{7'd10, 7'h7F, 7'd127, 7'd0, 7'd1, 7'd2, 7'd3, 7'd4};
        tb_notes[2] = 7'd70;
        record(2'd2, 3, 1, 1'b1);

        tb_notes = '{7'd33, 7'd44, 7'd55, 7'd66, 7'd77, 7'd88, 7'd99, 7'd11};
        record(2'd1, 2, 3, 1'b0);
        chk("queue_after_rst", 32'(q.size()), 32'd0);

        tb_notes = '{7'd20, 7'd21, 7'd22, 7'd23, 7'd24, 7'd25, 7'd26, 7'd27};
        record(2'd2, 2, 0, 1'b0);

        repeat (4) tick();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
